uart_tx_arbiter: RTL and testbench

- Round-robin scheduler that shares one `uart_tx_8n1` transmitter between `NUM_REQ` byte producers, such as switch reporters and status monitors.
- Each requester has a one-byte holding slot.
- The arbiter picks a full slot, drives the UART's `send_enable`/`send_data`, and tracks the UART `busy` flag, which is synchronised from the baud-clock side, to sequence one frame at a time.
- It sits between the producers and the `uart_tx_8n1` + `baud_clk_generator` pair at the top level.

---
 rtl/uart_arb_pkg.sv | 23 ++
 rtl/rr_pick.sv | 31 +++
 rtl/uart_tx_arbiter.sv | 174 +++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_arb_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM state codes, tag nibble, defaults.
// The tag states are only reached when UART_ARB_TAG_EN is defined.
package uart_arb_pkg;

  typedef logic [2:0] arb_state_t;

  localparam arb_state_t StIdle    = 3'd0;
  localparam arb_state_t StSend    = 3'd1;
  localparam arb_state_t StWaitHi  = 3'd2;
  localparam arb_state_t StWaitLo  = 3'd3;
  localparam arb_state_t StTagSend = 3'd4;
  localparam arb_state_t StTagHi   = 3'd5;
  localparam arb_state_t StTagLo   = 3'd6;

  localparam logic [3:0] TAG_NIBBLE = 4'hA;

  localparam int unsigned ACK_TIMEOUT_DEFAULT = 1024;

  function automatic logic [7:0] make_tag(input logic [2:0] id);
    return {TAG_NIBBLE, 1'b0, id};
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first full slot strictly after `last`, wrapping around.
module rr_pick #(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         full,
  input  logic [$clog2(NUM_REQ)-1:0] last,
  output logic                       grant_valid,
  output logic [$clog2(NUM_REQ)-1:0] grant_idx
);

  localparam int unsigned IdxW = $clog2(NUM_REQ);

  always_comb begin
    int idx;
    logic [IdxW-1:0] idx_w;
    idx         = 0;
    idx_w       = '0;
    grant_valid = 1'b0;
    grant_idx   = '0;
    // Descending offset so the nearest full slot is the last (winning) assignment.
    for (int k = int'(NUM_REQ); k >= 1; k--) begin
      idx   = (int'(last) + k) % int'(NUM_REQ);
      idx_w = IdxW'(idx);
      if (full[idx_w]) begin
        grant_valid = 1'b1;
        grant_idx   = idx_w;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between NUM_REQ one-byte slots.
// Optional tag frame ahead of each data byte when UART_ARB_TAG_EN is defined.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned ACK_TIMEOUT = ACK_TIMEOUT_DEFAULT
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [8*NUM_REQ-1:0]       req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       uart_send_en,
  output logic [7:0]                 uart_data,
  input  logic                       uart_busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       timeout_err
);

  localparam int unsigned IdxW = $clog2(NUM_REQ);
  localparam int unsigned CntW = $clog2(ACK_TIMEOUT + 1);

  logic [SYNC_STAGES-1:0] busy_sync_q, busy_sync_d;
  logic                   busy_s;
  logic [NUM_REQ-1:0]     full_q, full_d;
  logic [8*NUM_REQ-1:0]   slot_q, slot_d;
  arb_state_t             state_q, state_d;
  logic [IdxW-1:0]        grant_q, grant_d, last_q, last_d;
  logic [7:0]             data_q, data_d;
  logic                   send_en_q, send_en_d;
  logic                   tmo_q, tmo_d;
  logic [CntW-1:0]        cnt_q, cnt_d, cnt_inc;
  logic                   ack_timeout;
  logic                   clr;
  logic                   pick_valid;
  logic [IdxW-1:0]        pick_idx;

  rr_pick #(
    .NUM_REQ(NUM_REQ)
  ) u_rr_pick (
    .full       (full_q),
    .last       (last_q),
    .grant_valid(pick_valid),
    .grant_idx  (pick_idx)
  );

  assign busy_sync_d = {busy_sync_q[SYNC_STAGES-2:0], uart_busy};
  assign busy_s      = busy_sync_q[SYNC_STAGES-1];

  // Saturating count; reaching ACK_TIMEOUT in a wait state means the UART never answered.
  assign cnt_inc     = (cnt_q == CntW'(ACK_TIMEOUT)) ? cnt_q : cnt_q + 1'b1;
  assign ack_timeout = (cnt_inc == CntW'(ACK_TIMEOUT));

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    last_d    = last_q;
    data_d    = data_q;
    send_en_d = send_en_q;
    tmo_d     = 1'b0;
    cnt_d     = cnt_q;
    clr       = 1'b0;
    full_d    = full_q | (req_valid & ~full_q);
    slot_d    = slot_q;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (req_valid[i] && !full_q[i]) slot_d[8*i +: 8] = req_data[8*i +: 8];
    end

    case (state_q)
      StIdle: begin
        if (pick_valid && !busy_s) begin
          grant_d   = pick_idx;
          last_d    = pick_idx;
          send_en_d = 1'b1;
          cnt_d     = '0;
`ifdef UART_ARB_TAG_EN
          data_d    = make_tag(3'(pick_idx));
          state_d   = StTagSend;
`else
          data_d    = slot_q[8*pick_idx +: 8];
          state_d   = StSend;
`endif
        end
      end
      StSend: begin
        cnt_d   = cnt_inc;
        state_d = StWaitHi;
      end
      StWaitHi: begin
        if (busy_s) begin
          send_en_d = 1'b0;
          clr       = 1'b1;
          state_d   = StWaitLo;
        end else if (ack_timeout) begin
          send_en_d = 1'b0;
          clr       = 1'b1;
          tmo_d     = 1'b1;
          state_d   = StIdle;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      StWaitLo: begin
        if (!busy_s) state_d = StIdle;
      end
`ifdef UART_ARB_TAG_EN
      StTagSend: begin
        cnt_d   = cnt_inc;
        state_d = StTagHi;
      end
      StTagHi: begin
        if (busy_s) begin
          send_en_d = 1'b0;
          state_d   = StTagLo;
        end else if (ack_timeout) begin
          // Tag lost: the data byte is discarded with it.
          send_en_d = 1'b0;
          clr       = 1'b1;
          tmo_d     = 1'b1;
          state_d   = StIdle;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      StTagLo: begin
        if (!busy_s) begin
          send_en_d = 1'b1;
          data_d    = slot_q[8*grant_q +: 8];
          cnt_d     = '0;
          state_d   = StSend;
        end
      end
`endif
      default: state_d = StIdle;
    endcase

    if (clr) full_d[grant_q] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_sync_q <= '0;
      full_q      <= '0;
      slot_q      <= '0;
      state_q     <= StIdle;
      grant_q     <= '0;
      last_q      <= IdxW'(NUM_REQ - 1);
      data_q      <= '0;
      send_en_q   <= 1'b0;
      tmo_q       <= 1'b0;
      cnt_q       <= '0;
    end else begin
      busy_sync_q <= busy_sync_d;
      full_q      <= full_d;
      slot_q      <= slot_d;
      state_q     <= state_d;
      grant_q     <= grant_d;
      last_q      <= last_d;
      data_q      <= data_d;
      send_en_q   <= send_en_d;
      tmo_q       <= tmo_d;
      cnt_q       <= cnt_d;
    end
  end

  assign req_ready    = ~full_q;
  assign uart_send_en = send_en_q;
  assign uart_data    = data_q;
  assign grant_id     = grant_q;
  assign timeout_err  = tmo_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter with a behavioural UART busy model.
module tb_uart_tx_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        uart_send_en;
  logic [7:0]  uart_data;
  logic        uart_busy;
  logic [1:0]  grant_id;
  logic        timeout_err;

  int checks = 0;
  int errors = 0;

  // UART model controls and captured frames
  bit         model_respond = 1'b1;
  bit         force_hi      = 1'b0;
  int         ack_delay     = 3;
  int         hold_cycles   = 100;
  int         ack_cnt       = 0;
  int         busy_cnt      = 0;
  logic [7:0] frames[$];
  logic [1:0] gids[$];

  typedef struct packed {
    logic [3:0]  valid;
    logic [31:0] data;
    logic [2:0]  n;
    logic [31:0] bytes;
    logic [7:0]  gidv;
  } vec_t;

  vec_t vecs[7];

  uart_tx_arbiter #(
    .NUM_REQ    (4),
    .SYNC_STAGES(2),
    .ACK_TIMEOUT(16)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .uart_send_en(uart_send_en),
    .uart_data   (uart_data),
    .uart_busy   (uart_busy),
    .grant_id    (grant_id),
    .timeout_err (timeout_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    uart_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (force_hi) begin
        uart_busy = 1'b1;
      end else if (busy_cnt > 0) begin
        busy_cnt--;
        if (busy_cnt == 0) uart_busy = 1'b0;
      end else if (ack_cnt > 0) begin
        ack_cnt--;
        if (ack_cnt == 0) begin
          uart_busy = 1'b1;
          busy_cnt  = hold_cycles;
          frames.push_back(uart_data);
          gids.push_back(grant_id);
        end
      end else begin
        uart_busy = 1'b0;
        if (uart_send_en && model_respond) ack_cnt = ack_delay;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required finish before 500000");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  task automatic expect_frame(input string nm, input logic [7:0] eb, input logic [1:0] eg);
    int t;
    logic [7:0] b;
    logic [1:0] g;
    t = 0;
    while (frames.size() == 0 && t < 600) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (frames.size() == 0) begin
      errors++;
      $display("FAIL %s: no frame seen, required byte %0h gid %0d", nm, eb, eg);
    end else begin
      b = frames.pop_front();
      g = gids.pop_front();
      if (b !== eb || g !== eg) begin
        errors++;
        $display("FAIL %s: got byte %0h gid %0d required byte %0h gid %0d", nm, b, g, eb, eg);
      end
    end
  endtask

  task automatic expect_data(input string nm, input logic [1:0] gid, input logic [7:0] b);
`ifdef UART_ARB_TAG_EN
    expect_frame({nm, "_tag"}, {4'hA, 2'b00, gid}, gid);
`endif
    expect_frame(nm, b, gid);
  endtask

  task automatic wait_ready_all(input string nm);
    int t;
    t = 0;
    while (req_ready !== 4'hF && t < 300) begin
      @(negedge clk);
      t++;
    end
    chk(nm, 32'(req_ready), 32'hF);
  endtask

  task automatic wait_send_en(input string nm);
    int t;
    t = 0;
    while (!uart_send_en && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk(nm, 32'(uart_send_en), 32'h1);
  endtask

  task automatic load(input logic [3:0] v, input logic [31:0] d);
    @(negedge clk);
    req_valid = v;
    req_data  = d;
    @(negedge clk);
    req_valid = 4'h0;
  endtask

  task automatic do_reset(input bit busy_hi);
    int t;
    t = 0;
    while ((uart_busy || busy_cnt != 0 || ack_cnt != 0) && t < 500) begin
      @(negedge clk);
      t++;
    end
    force_hi  = busy_hi;
    req_valid = 4'h0;
    rst_n     = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    frames.delete();
    gids.delete();
  endtask

  initial begin
    int n;
    int tmo;
    int bad;
    logic [31:0] bs;
    logic [7:0]  gs;
    logic [7:0]  first_b;

    vecs[0] = '{4'b0100, 32'h005A0000, 3'd1, 32'h0000005A, 8'h02};
    vecs[1] = '{4'b1001, 32'hB30000A0, 3'd2, 32'h0000A0B3, 8'h03};
    vecs[2] = '{4'b0011, 32'h00000201, 3'd2, 32'h00000102, 8'h01};
    vecs[3] = '{4'b1010, 32'h88004400, 3'd2, 32'h00008844, 8'h0D};
    vecs[4] = '{4'b0001, 32'h000000FF, 3'd1, 32'h000000FF, 8'h00};
    vecs[5] = '{4'b1110, 32'h33323100, 3'd3, 32'h00333231, 8'h39};
    vecs[6] = '{4'b1000, 32'hC3000000, 3'd1, 32'h000000C3, 8'h03};

    rst_n     = 1'b0;
    req_valid = 4'h0;
    req_data  = 32'h0;
    repeat (3) @(negedge clk);
    chk("rst_send_en", 32'(uart_send_en), 32'h0);
    chk("rst_data", 32'(uart_data), 32'h0);
    chk("rst_grant", 32'(grant_id), 32'h0);
    chk("rst_tmo", 32'(timeout_err), 32'h0);
    chk("rst_ready", 32'(req_ready), 32'hF);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Single request: exact latency and busy-to-drop timing
`ifdef UART_ARB_TAG_EN
    first_b = 8'hA2;
`else
    first_b = 8'h5A;
`endif
    req_valid = 4'b0100;
    req_data  = 32'h005A0000;
    @(negedge clk);
    req_valid = 4'h0;
    chk("t1_ready_low", 32'(req_ready[2]), 32'h0);
    chk("t1_en_early", 32'(uart_send_en), 32'h0);
    @(negedge clk);
    chk("t1_en_high", 32'(uart_send_en), 32'h1);
    chk("t1_data", 32'(uart_data), 32'(first_b));
    chk("t1_grant", 32'(grant_id), 32'h2);
    n = 0;
    while (!uart_busy && n < 100) begin
      @(posedge clk);
      n++;
    end
    n = 1;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (uart_send_en && n < 50);
    chk("t1_drop_lat", 32'(n), 32'h3);
`ifndef UART_ARB_TAG_EN
    chk("t1_ready_back", 32'(req_ready[2]), 32'h1);
`endif
    expect_data("t1", 2'd2, 8'h5A);
    wait_ready_all("t1_ready_all");

    // Round-robin from reset with a reload of requester 1 during its frame
    do_reset(1'b0);
    load(4'b1111, 32'h13121110);
    expect_data("rr0", 2'd0, 8'h10);
    expect_data("rr1", 2'd1, 8'h11);
    n = 0;
    while (!req_ready[1] && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("rr_reload_ready", 32'(req_ready[1]), 32'h1);
    load(4'b0010, 32'h00002100);
    expect_data("rr2", 2'd2, 8'h12);
    expect_data("rr3", 2'd3, 8'h13);
    expect_data("rr4", 2'd1, 8'h21);

    for (int v = 0; v < 7; v++) begin
      wait_ready_all($sformatf("vec%0d_ready", v));
      load(vecs[v].valid, vecs[v].data);
      bs = vecs[v].bytes;
      gs = vecs[v].gidv;
      for (int k = 0; k < int'(vecs[v].n); k++) begin
        expect_data($sformatf("vec%0d_%0d", v, k), gs[2*k +: 2], bs[8*k +: 8]);
      end
    end
    wait_ready_all("vec_end_ready");

    // Timeout: UART never answers requester 0, requester 1 is served afterwards
    do_reset(1'b0);
    model_respond = 1'b0;
    load(4'b0011, 32'h00006677);
`ifdef UART_ARB_TAG_EN
    first_b = 8'hA0;
`else
    first_b = 8'h77;
`endif
    wait_send_en("to_en_rise");
    n   = 0;
    tmo = 0;
    bad = 0;
    while (uart_send_en && n < 100) begin
      if (uart_data !== first_b) bad++;
      if (timeout_err) tmo++;
      @(negedge clk);
      n++;
    end
    model_respond = 1'b1;
    chk("to_len", 32'(n), 32'd16);
    chk("to_data_stable", 32'(bad), 32'h0);
    chk("to_slot0_clear", 32'(req_ready[0]), 32'h1);
    chk("to_slot1_full", 32'(req_ready[1]), 32'h0);
    if (timeout_err) tmo++;
    repeat (4) begin
      @(negedge clk);
      if (timeout_err) tmo++;
    end
    chk("to_pulse_once", 32'(tmo), 32'h1);
    expect_data("to_next", 2'd1, 8'h66);
    chk("to_no_stale", 32'(frames.size()), 32'h0);

    // Reset during WAIT_HI
    do_reset(1'b0);
    model_respond = 1'b0;
    load(4'b0100, 32'h00990000);
    wait_send_en("rm_en_rise");
    repeat (5) @(negedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("rm_en_async", 32'(uart_send_en), 32'h0);
    chk("rm_ready_async", 32'(req_ready), 32'hF);
    @(negedge clk);
    rst_n         = 1'b1;
    model_respond = 1'b1;
    n = 0;
    repeat (40) begin
      @(negedge clk);
      if (uart_send_en) n++;
    end
    chk("rm_no_stale_en", 32'(n), 32'h0);
    chk("rm_no_frames", 32'(frames.size()), 32'h0);

    // Busy high at reset release
    do_reset(1'b1);
    load(4'b0001, 32'h0000005C);
    n = 0;
    repeat (20) begin
      @(negedge clk);
      if (uart_send_en) n++;
    end
    chk("bs_no_en", 32'(n), 32'h0);
    force_hi = 1'b0;
    expect_data("bs_send", 2'd0, 8'h5C);
    wait_ready_all("bs_ready_all");

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
